// File: rtl/counting_sort_stream.sv
// Streaming counting sorter: histograms a batch of keys, then drains it as a sorted stream.
// Define COUNTING_SORT_DESCEND_EN for non-increasing output order (default is ascending).
module counting_sort_stream #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned DATA_SIZE  = 4,
    parameter int unsigned MAX        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  write_valid_i,
    output logic                  write_ready_o,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  write_last_i,
    input  logic                  read_ready_i,
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  read_last_o,
    output logic                  drop_o
);

    localparam int unsigned CntW = $clog2(DATA_SIZE + 1);
    localparam int unsigned BinW = (MAX > 1) ? $clog2(MAX) : 1;

    typedef enum logic {StLoad, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q [MAX];
    logic [CntW-1:0] count_d [MAX];
    logic [CntW-1:0] n_q, n_d, acc_q, acc_d, cur_cnt;
    logic [BinW-1:0] bin_q, bin_d, bin_step, key_idx;
    logic            drop_q, drop_d;
    logic            in_range, accept, close, read_hs;

`ifdef COUNTING_SORT_DESCEND_EN
    localparam logic [BinW-1:0] ScanStart = BinW'(MAX - 1);
    assign bin_step = bin_q - BinW'(1);
`else
    localparam logic [BinW-1:0] ScanStart = '0;
    assign bin_step = bin_q + BinW'(1);
`endif

    assign in_range = (32'(write_data_i) < MAX);
    assign key_idx  = write_data_i[BinW-1:0];
    assign accept   = (state_q == StLoad) && write_valid_i;
    // Dropped keys still count toward the DATA_SIZE batch limit.
    assign close    = accept && (write_last_i || (acc_q == CntW'(DATA_SIZE - 1)));
    assign read_hs  = read_valid_o && read_ready_i;
    assign drop_o   = drop_q;

    always_comb begin
        cur_cnt = '0;
        for (int unsigned i = 0; i < MAX; i++) begin
            if (bin_q == BinW'(i)) cur_cnt = count_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StLoad;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (close && (n_d != '0)) state_d = StDrain;
            StDrain: if (read_hs && (n_q == CntW'(1))) state_d = StLoad;
        endcase
    end

    always_comb begin
        count_d = count_q;
        n_d     = n_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        drop_d  = 1'b0;
        if (state_q == StLoad) begin
            bin_d = ScanStart;
            if (accept) begin
                acc_d  = close ? '0 : acc_q + CntW'(1);
                drop_d = !in_range;
                if (in_range) begin
                    n_d = n_q + CntW'(1);
                    for (int unsigned i = 0; i < MAX; i++) begin
                        if (key_idx == BinW'(i)) count_d[i] = count_q[i] + CntW'(1);
                    end
                end
            end
        end else begin
            if (read_hs) begin
                n_d = n_q - CntW'(1);
                for (int unsigned i = 0; i < MAX; i++) begin
                    if (bin_q == BinW'(i)) count_d[i] = count_q[i] - CntW'(1);
                end
            end
            if (read_hs && (n_q == CntW'(1))) begin
                bin_d = ScanStart;
            end else if ((cur_cnt == '0) || (read_hs && (cur_cnt == CntW'(1)))) begin
                bin_d = bin_step;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '{default: '0};
            n_q     <= '0;
            acc_q   <= '0;
            bin_q   <= ScanStart;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        write_ready_o = (state_q == StLoad);
        read_valid_o  = (state_q == StDrain) && (cur_cnt != '0);
        read_data_o   = (state_q == StDrain) ? DATA_WIDTH'(bin_q) : '0;
        read_last_o   = read_valid_o && (n_q == CntW'(1));
    end

endmodule

// File: tb/tb_counting_sort_stream.sv
// Bench for counting_sort_stream: a default instance plus a MAX=20 instance for drop cases,
// checked every cycle against a queue-based sorting model.
module tb_counting_sort_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wv = 1'b0;
    logic       wl = 1'b0;
    logic       rr = 1'b0;
    logic [4:0] wd = '0;
    logic       sel = 1'b0;

    logic       wr0, rv0, rl0, dr0, wr1, rv1, rl1, dr1;
    logic [4:0] rd0, rd1;
    logic       write_ready, read_valid, read_last, drop;
    logic [4:0] read_data;

    always #5 clk = ~clk;

    counting_sort_stream dut (
        .clk_i(clk), .rst_i(rst), .write_valid_i(wv & ~sel), .write_ready_o(wr0),
        .write_data_i(wd), .write_last_i(wl), .read_ready_i(rr & ~sel), .read_valid_o(rv0),
        .read_data_o(rd0), .read_last_o(rl0), .drop_o(dr0)
    );

    counting_sort_stream #(.MAX(20)) dut20 (
        .clk_i(clk), .rst_i(rst), .write_valid_i(wv & sel), .write_ready_o(wr1),
        .write_data_i(wd), .write_last_i(wl), .read_ready_i(rr & sel), .read_valid_o(rv1),
        .read_data_o(rd1), .read_last_o(rl1), .drop_o(dr1)
    );

    assign write_ready = sel ? wr1 : wr0;
    assign read_valid  = sel ? rv1 : rv0;
    assign read_data   = sel ? rd1 : rd0;
    assign read_last   = sel ? rl1 : rl0;
    assign drop        = sel ? dr1 : dr0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Model: keys pending in the open batch, sorted keys awaiting output, drop bookkeeping.
    int  pend[$];
    int  exp_q[$];
    int  got[$];
    int  got_last[$];
    int  acc_cnt = 0;
    int  drop_cnt = 0;
    bit  drop_pend = 0;
    bit  stall_prev = 0;
    int  prev_data = 0;
    int  prev_last = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_write_ready", int'(write_ready), 1);
            chk("rst_read_valid", int'(read_valid), 0);
            pend.delete();
            exp_q.delete();
            acc_cnt    = 0;
            drop_pend  = 0;
            stall_prev = 0;
        end else begin
            automatic bit exp_ready = (exp_q.size() == 0);
            automatic int max_v = sel ? 20 : 32;
            chk("write_ready", int'(write_ready), int'(exp_ready));
            chk("drop", int'(drop), int'(drop_pend));
            if (drop) drop_cnt++;
            if (exp_q.size() == 0) begin
                chk("read_valid_idle", int'(read_valid), 0);
            end else if (read_valid) begin
                chk("read_data", int'(read_data), exp_q[0]);
                chk("read_last", int'(read_last), int'(exp_q.size() == 1));
            end
            if (stall_prev) begin
                chk("stall_valid", int'(read_valid), 1);
                chk("stall_data", int'(read_data), prev_data);
                chk("stall_last", int'(read_last), prev_last);
            end
            stall_prev = read_valid && !rr;
            prev_data  = int'(read_data);
            prev_last  = int'(read_last);
            if (read_valid && rr) begin
                got.push_back(int'(read_data));
                got_last.push_back(int'(read_last));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            drop_pend = 0;
            if (wv && exp_ready) begin
                acc_cnt++;
                if (int'(wd) < max_v) pend.push_back(int'(wd));
                else drop_pend = 1;
                if (wl || acc_cnt == 4) begin
`ifdef COUNTING_SORT_DESCEND_EN
                    pend.rsort();
`else
                    pend.sort();
`endif
                    exp_q = pend;
                    pend.delete();
                    acc_cnt = 0;
                end
            end
        end
    end

    task automatic send(input int a, input int b, input int c, input int d, input int cnt,
                        input bit last);
        int ks[4];
        ks = '{a, b, c, d};
        for (int i = 0; i < cnt; i++) begin
            wv = 1'b1;
            wd = 5'(ks[i]);
            wl = last && (i == cnt - 1);
            @(posedge clk); #1;
        end
        wv = 1'b0;
        wl = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!write_ready && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!write_ready) chk("drain_timeout", 0, 1);
    endtask

    // Expected read sequence given in ascending order; reversed for the descending build.
    task automatic check_seq(input string name, input int a, input int b, input int c,
                             input int d, input int cnt);
        int e[$];
        int lsum = 0;
        e = '{a, b, c, d};
        while (e.size() > cnt) void'(e.pop_back());
`ifdef COUNTING_SORT_DESCEND_EN
        e.reverse();
`endif
        chk({name, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt && i < got.size(); i++) begin
            chk({name, "_key"}, got[i], e[i]);
            if (i < cnt - 1) lsum += got_last[i];
        end
        chk({name, "_early_last"}, lsum, 0);
        if (got.size() == cnt && cnt > 0) chk({name, "_final_last"}, got_last[cnt-1], 1);
        got.delete();
        got_last.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dcyc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_read_data", int'(read_data), 0);
        chk("reset_read_last", int'(read_last), 0);
        chk("reset_drop", int'(drop), 0);

        // Full batch closed by count; latency and drain length with ready held high.
        rr = 1'b1;
        send(7, 3, 7, 0, 4, 1'b0);
        lat = 0;
        while (!read_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        dcyc = lat;
        while (!write_ready && dcyc < 200) begin
            @(posedge clk); #1;
            dcyc++;
        end
`ifdef COUNTING_SORT_DESCEND_EN
        chk("first_valid_latency", lat, 24);
        chk("drain_cycles", dcyc, 33);
`else
        chk("first_valid_latency", lat, 0);
        chk("drain_cycles", dcyc, 9);
`endif
        check_seq("basic", 0, 3, 7, 7, 4);

        // Short batch, then a full batch of duplicates.
        send(5, 2, 0, 0, 2, 1'b1);
        wait_idle(100);
        check_seq("short", 2, 5, 0, 0, 2);
        send(1, 1, 1, 1, 4, 1'b0);
        wait_idle(100);
        check_seq("dups", 1, 1, 1, 1, 4);

        // Backpressure with pseudo-random ready.
        rr = 1'b0;
        send(31, 0, 31, 16, 4, 1'b0);
        for (int i = 0; i < 300 && !write_ready; i++) begin
            rr = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rr = 1'b1;
        wait_idle(100);
        check_seq("backpressure", 0, 16, 31, 31, 4);

        // Drops on the MAX=20 instance.
        sel = 1'b1;
        drop_cnt = 0;
        send(25, 4, 19, 25, 4, 1'b0);
        wait_idle(100);
        repeat (2) @(posedge clk);
        #1 chk("drop_pulses", drop_cnt, 2);
        check_seq("drop", 4, 19, 0, 0, 2);
        drop_cnt = 0;
        send(25, 0, 0, 0, 1, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("all_dropped_ready", int'(write_ready), 1);
        chk("all_dropped_drop", drop_cnt, 1);
        check_seq("all_dropped", 0, 0, 0, 0, 0);
        sel = 1'b0;

        // Asynchronous reset after the first read.
        send(9, 9, 8, 1, 4, 1'b0);
        for (int i = 0; i < 100 && got.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1 chk("async_reset_valid", int'(read_valid), 0);
        chk("async_reset_ready", int'(write_ready), 1);
`ifdef COUNTING_SORT_DESCEND_EN
        chk("pre_reset_key", got.size() > 0 ? got[0] : -1, 9);
`else
        chk("pre_reset_key", got.size() > 0 ? got[0] : -1, 1);
`endif
        got.delete();
        got_last.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(2, 2, 2, 2, 4, 1'b0);
        wait_idle(100);
        repeat (2) @(posedge clk);
        #1 check_seq("after_reset", 2, 2, 2, 2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counting_sort_stream.md
# counting_sort_stream

Parametrised streaming counting sorter, the next generation of the team's fixed-size counting sort. Keys arrive on a valid/ready write stream and are histogrammed on acceptance. The block then drains the histogram as a sorted valid/ready read stream with an end-of-batch marker. Batches may be shorter than `DATA_SIZE`, the histogram clears itself during drain, and sort order is selectable at build time.

## Interface
- `DATA_WIDTH`, 5, key width in bits.
- `DATA_SIZE`, 4, maximum keys per batch; ≥1.
- `MAX`, 32, number of histogram bins; 1 ≤ `MAX` ≤ 2**`DATA_WIDTH`.
- `clk_i` in 1: the block's one clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `write_valid_i` in 1: key offered.
- `write_ready_o` out 1: key accepted this cycle when valid & ready.
- `write_data_i` in `DATA_WIDTH`: key.
- `write_last_i` in 1: qualifies the accepted key as the final key of a batch.
- `read_ready_i` in 1: downstream can take a key.
- `read_valid_o` out 1: sorted key available.
- `read_data_o` out `DATA_WIDTH`: sorted key.
- `read_last_o` out 1: final key of the batch; meaningful only with `read_valid_o`.
- `drop_o` out 1: one-cycle pulse when an accepted key is ≥ `MAX`.

## Operation
- Storage:
  - `COUNT[MAX]` counters, each `$clog2(DATA_SIZE+1)` bits.
  - Batch counter `n`, `$clog2(DATA_SIZE+1)` bits.
  - Bin pointer `bin`, `$clog2(MAX)` bits (≥1).
  - Two-state FSM: LOAD, DRAIN.
- Reset (async, while `rst_i`=1):
  - state=LOAD, all `COUNT`=0, `n`=0, `bin`=scan start.
  - `write_ready_o`=1 and `read_valid_o`=0.
  - `read_data_o`=0, `read_last_o`=0, `drop_o`=0.
- LOAD:
  - `write_ready_o`=1 and `read_valid_o`=0.
  - On each accepted key with key < `MAX`: `COUNT[key]`+1 and `n`+1.
  - On each accepted key with key ≥ `MAX`: no count and no `n` change; `drop_o` pulses the next cycle.
  - Batch closes when an accepted key has `write_last_i`=1, or when it is the `DATA_SIZE`-th accepted key, dropped keys included.
  - On close: go to DRAIN with `bin`=scan start. If the closing `n` is 0 (all keys dropped), stay in LOAD instead.
- DRAIN:
  - `write_ready_o`=0.
  - `read_valid_o`=(`COUNT[bin]`≠0), `read_data_o`=`bin`, `read_last_o`=`read_valid_o` & (`n`==1).
  - On handshake: `COUNT[bin]`−1 and `n`−1.
  - `bin` steps toward scan end when `COUNT[bin]`==0, or when a handshake takes the bin's last key.
  - After the handshake with `n`==1: go to LOAD with `bin`=scan start. All counters are zero at that point.
- Output is held stable while `read_valid_o`=1 and `read_ready_i`=0.
- Duplicates are emitted back to back from one bin.

## Timing
- `read_valid_o`, `read_data_o`, `read_last_o` and `write_ready_o` decode registered state only; there is no input-to-output combinational path.
- Latency:
  - Closing write handshake at cycle t: DRAIN from t+1.
  - First `read_valid_o` at t+1+z, where z = empty bins scanned before the first occupied bin.
- Drain throughput:
  - One key per cycle within a bin and across adjacent occupied bins.
  - One idle cycle per empty bin skipped.
  - Worst-case drain is `n`+`MAX`−1 cycles with `read_ready_i` held high.
- First key of the next batch is accepted in the cycle after the final read handshake.
- Counter arithmetic never wraps: `COUNT` saturates structurally because `n` ≤ `DATA_SIZE`.
- Reset asserted mid-LOAD or mid-DRAIN discards the batch immediately and clears all counters. There is no partial output afterwards.

## Configuration
- `COUNTING_SORT_DESCEND_EN` defined:
  - Scan start is `MAX`−1, `bin` decrements, output is non-increasing.
- `COUNTING_SORT_DESCEND_EN` undefined:
  - Scan start is 0, `bin` increments, output is non-decreasing.
- Ports and timing are identical in both builds.

## Test plan
- Defaults, ascending. Write 7,3,7,0 with no last and read_ready=1 → reads 0,3,7,7; `read_last_o` only on the second 7; first valid 1 cycle after the close; `write_ready_o` returns 1 after the final read.
- Short batch. Write 5,2 with `write_last_i` on 2 → reads 2,5, last on 5. Then a full batch 1,1,1,1 → four 1s, confirming the counters were cleared.
- Backpressure. `read_ready_i` toggles pseudo-randomly over batch 31,0,31,16 → `read_data_o`/`read_last_o` are stable while stalled; order 0,16,31,31.
- Drop. `MAX`=20 with keys 25,4,19,25 → `drop_o` pulses twice; reads 4,19. Also a batch of only key 25 with last → no read output, block stays in LOAD.
- Reset mid-drain. Assert `rst_i` asynchronously after the first read of 9,9,8,1 → `read_valid_o`=0 immediately. Next batch 2,2,2,2 → exactly four 2s, no residue.
- `COUNTING_SORT_DESCEND_EN` build. Write 7,3,7,0 → reads 7,7,3,0, last on 0.
